mcp_spi_master: RTL and testbench
=================================

// Module: mcp_spi_master
// PURPOSE
// - SPI source (mode 0, CPOL=0/CPHA=0) driving one MCP23S17-style SPI sink; upstream peer of the SPI responder.
// - Turns one register command (rw, addr, wdata) into a 24-bit frame: opcode, addr, data. Returns read data on a response strobe.
// - Sits between the PS/AXI register bank (cmd/rsp side) and the sclk/csn/mosi/miso pins.
// PARAMETERS
// - CLK_DIV   4     clk cycles per SCLK half-period; legal >=2
// - DEV_ADDR  3'b000  hardware address field placed in opcode[3:1]
// - CSS_CYC   2     clk cycles CSN low before first SCLK rise; legal >=1
// - CSH_CYC   2     clk cycles CSN held low after last SCLK fall; legal >=1
// PORTS
// - clk        in   1  system clock; all logic on posedge
// - rstn       in   1  asynchronous, active-low reset
// - cmd_valid  in   1  command request
// - cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&cmd_ready
// - cmd_rw     in   1  0=write, 1=read (becomes opcode[0])
// - cmd_addr   in   8  register address
// - cmd_wdata  in   8  write data; ignored for reads, but still shifted out
// - rsp_valid  out  1  one-cycle pulse at transaction end (reads and writes)
// - rsp_rdata  out  8  read data, valid with rsp_valid, held until next rsp_valid; 0x00 after a write
// - busy       out  1  high from accept cycle+1 until rsp_valid cycle inclusive
// - sclk_o     out  1  SPI clock, idle low
// - csn_o      out  1  chip select, active low
// - mosi_o     out  1  serial data to sink, MSB first
// - miso_i     in   1  serial data from sink
// BEHAVIOUR
// - Reset values: sclk_o=0, csn_o=1, mosi_o=0, rsp_valid=0, rsp_rdata=8'h00, busy=0, state=IDLE, so cmd_ready=1.
// - Frame, MSB first: {4'b0100, DEV_ADDR, cmd_rw}, cmd_addr, cmd_wdata (write) or cmd_wdata don't-care (read). All fields latched at accept.
// - States:
//   - IDLE: wait for accept.
//   - CS_SETUP: CSS_CYC cycles; csn_o=0; mosi_o=frame[23].
//   - SHIFT: 48 half-periods, each CLK_DIV cycles. SCLK rises on SHIFT entry. Odd half-periods high, even half-periods low.
//   - CS_HOLD: CSH_CYC cycles; sclk_o=0, csn_o=0.
//   - FLUSH: only with the macro.
//   - Return to IDLE: csn_o=1, rsp_valid=1 in the same cycle.
// - SCLK edges:
//   - Rising edge k (1..24): sample miso_i into rx shift reg in the clk cycle sclk_o goes 1.
//   - Falling edge k: mosi_o advances to frame[23-k], in the cycle sclk_o goes 0. mosi_o=0 after falling edge 24.
// - rsp_rdata = bits sampled on rising edges 17..24, MSB first (the sink launches read data on the falling edge after rise 16).
// - Latency, accept cycle to rsp_valid: 1+CSS_CYC+48*CLK_DIV+CSH_CYC cycles. The macro adds 2*CLK_DIV+1.
// - cmd_valid while busy: ignored, not queued. cmd_ready=1 again the cycle after rsp_valid; back-to-back min CSN-high = 1 cycle (no flush).
// - Reset mid-frame: outputs return to reset values immediately; no rsp_valid for the aborted frame.
// - Counters: half-period counter $clog2(CLK_DIV) bits; edge counter 6 bits (0..48), no wrap.
// CONFIGURATION
// - Macro SPI_FLUSH_CLK_EN. The sink resets its state only on an SCLK rise, and after a read it needs one extra rise.
// - Defined: after CS_HOLD, drive csn_o=1 for 1 cycle, then one SCLK pulse (CLK_DIV high, CLK_DIV low) with csn_o=1 and mosi_o=0, then IDLE with rsp_valid.
// - Undefined: no FLUSH state; SCLK pulse count per frame is exactly 24.
// STRUCTURE
// - mcp_spi_pkg: state enum, MCP_OPCODE_HI=4'b0100, FRAME_BITS=24, RD_FIRST_EDGE=17.
// - Sub-module spi_clk_gen: half-period tick counter plus sclk toggle. Inputs: enable and restart. Outputs: rise_tick and fall_tick.
// - Top: FSM, tx/rx shift registers, edge counter, response register.
// TESTING
// - Write, CLK_DIV=4, DEV_ADDR=0: rw=0, addr=0x0A, wdata=0x5A -> MOSI bytes 0x40,0x0A,0x5A; 24 SCLK rises; rsp_valid after 1+2+192+2=197 cycles; rsp_rdata=0x00.
// - Read against SPI sink model with td0=0xF0: rw=1, addr=0x12 -> MOSI 0x41,0x12; rsp_rdata=0xF0. Repeat with td0=0x0F -> 0x0F.
// - DEV_ADDR=3'b101: write addr=0x00, wdata=0xFF -> opcode byte 0x4A; read -> opcode 0x4B.
// - Back-to-back: cmd_valid held high with 3 commands -> 3 frames; csn_o high >=1 cycle between frames; extra cmd_valid pulses during busy are dropped.
// - Reset mid-frame: assert rstn=0 at SCLK rise 10 -> csn_o=1 and sclk_o=0 the same cycle; no rsp_valid; next read returns correct data.
// - With SPI_FLUSH_CLK_EN: read 0x12 then write 0x0A -> 25 SCLK rises per frame, 25th with csn_o=1; the sink accepts the second frame correctly.

Source files
------------

// File: rtl/mcp_spi_pkg.sv
// ---------------------------------------------------------------------------
// mcp_spi_pkg
// Shared types and constants for the MCP23S17-style SPI master.
//   state_e        : master FSM states (ST_FLUSH only reachable when the
//                    SPI_FLUSH_CLK_EN macro is defined)
//   MCP_OPCODE_HI  : fixed upper nibble of the device opcode
//   FRAME_BITS     : opcode + address + data bits per frame
//   RD_FIRST_EDGE  : first SCLK rise carrying read data from the sink
//   mcp_frame()    : builds the 24-bit MSB-first frame
// ---------------------------------------------------------------------------
package mcp_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_FLUSH
    } state_e;

    localparam logic [3:0] MCP_OPCODE_HI = 4'b0100;
    localparam int         FRAME_BITS    = 24;
    localparam int         RD_FIRST_EDGE = 17;
    localparam int         HALF_PERIODS  = 2 * FRAME_BITS;

    function automatic logic [FRAME_BITS-1:0] mcp_frame(
        input logic [2:0] dev,
        input logic       rw,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        return {MCP_OPCODE_HI, dev, rw, addr, wdata};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// ---------------------------------------------------------------------------
// spi_clk_gen
// Half-period tick counter and SCLK toggle for the SPI master.
//   clk, rstn  : system clock, async active-low reset
//   enable     : count half-periods and toggle SCLK at each half-period end
//   restart    : force a rising SCLK edge on the next clk edge, counter cleared
//   hold_low   : suppress the rise that would end a low half-period
//   sclk_o     : registered SPI clock, idle low
//   rise_tick  : SCLK goes 1 at the coming clk edge
//   fall_tick  : SCLK goes 0 at the coming clk edge
//   half_end   : last clk cycle of the current half-period
// ---------------------------------------------------------------------------
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic restart,
    input  logic hold_low,
    output logic sclk_o,
    output logic rise_tick,
    output logic fall_tick,
    output logic half_end
);

    localparam int                CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    always_comb begin
        half_end  = enable && (cnt_q == CNT_LAST);
        rise_tick = restart || (half_end && !sclk_q && !hold_low);
        fall_tick = half_end && sclk_q;

        cnt_d = '0;
        if (enable && !restart && !half_end) begin
            cnt_d = cnt_q + 1'b1;
        end

        sclk_d = sclk_q;
        if (rise_tick) begin
            sclk_d = 1'b1;
        end else if (fall_tick) begin
            sclk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/mcp_spi_master.sv
// ---------------------------------------------------------------------------
// mcp_spi_master
// SPI mode-0 master for one MCP23S17-style sink. A register command
// (rw, addr, wdata) becomes a 24-bit frame {0100, DEV_ADDR, rw}, addr, data,
// sent MSB first; read data (rises 17..24) is returned with rsp_valid.
//   cmd_valid/cmd_ready/cmd_rw/cmd_addr/cmd_wdata : command side
//   rsp_valid/rsp_rdata                            : response strobe + data
//   busy                                           : transaction in flight
//   sclk_o/csn_o/mosi_o/miso_i                     : SPI pins
// Optional feature (macro SPI_FLUSH_CLK_EN): after CS_HOLD, deselect for one
// cycle and send one extra SCLK pulse with CSN high so the sink re-arms.
// ---------------------------------------------------------------------------
module mcp_spi_master
    import mcp_spi_pkg::*;
#(
    parameter int         CLK_DIV  = 4,
    parameter logic [2:0] DEV_ADDR = 3'b000,
    parameter int         CSS_CYC  = 2,
    parameter int         CSH_CYC  = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    localparam int               CYC_MAX   = (CSS_CYC > CSH_CYC) ? CSS_CYC : CSH_CYC;
    localparam int               CYC_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
    localparam logic [CYC_W-1:0] CSS_LAST  = CYC_W'(CSS_CYC - 1);
    localparam logic [CYC_W-1:0] CSH_LAST  = CYC_W'(CSH_CYC - 1);
    localparam logic [5:0]       EDGE_LAST = 6'(HALF_PERIODS);
    localparam logic [5:0]       RD_FIRST  = 6'(RD_FIRST_EDGE);

    state_e                  state_q, state_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [5:0]              edge_q, edge_d;
    logic [FRAME_BITS-1:0]   tx_q, tx_d;
    logic [7:0]              rx_q, rx_d;
    logic                    rw_q, rw_d;
    logic                    csn_q, csn_d;
    logic                    mosi_q, mosi_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [7:0]              rsp_rdata_q, rsp_rdata_d;
    logic                    busy_q, busy_d;

    logic                    cg_enable, cg_restart, cg_hold_low;
    logic                    rise_tick, fall_tick, half_end;
    logic [FRAME_BITS-1:0]   frame_w;
    logic [5:0]              rise_num;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (cg_enable),
        .restart   (cg_restart),
        .hold_low  (cg_hold_low),
        .sclk_o    (sclk_o),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .half_end  (half_end)
    );

    assign frame_w   = mcp_frame(DEV_ADDR, cmd_rw, cmd_addr, cmd_wdata);
    // busy_q still high in the response cycle keeps ready low for that cycle
    assign cmd_ready = (state_q == ST_IDLE) && !busy_q;
    // Edge count is even before every rise, so rise number = edges/2 + 1
    assign rise_num  = {1'b0, edge_q[5:1]} + 6'd1;

    // Clock generator control
    always_comb begin
        cg_enable   = (state_q == ST_SHIFT) || ((state_q == ST_FLUSH) && (edge_q != 6'd0));
        cg_restart  = ((state_q == ST_CS_SETUP) && (cyc_q == CSS_LAST)) ||
                      ((state_q == ST_FLUSH) && (edge_q == 6'd0));
        // Final low half-period of the frame and the flush low half end without a rise
        cg_hold_low = (state_q == ST_FLUSH) || (edge_q == EDGE_LAST);
    end

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        edge_d      = edge_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        rw_d        = rw_q;
        csn_d       = csn_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;

        if (rise_tick || fall_tick) begin
            edge_d = edge_q + 6'd1;
        end
        if (rise_tick && (state_q != ST_FLUSH) && (rise_num >= RD_FIRST)) begin
            rx_d = {rx_q[6:0], miso_i};
        end
        // tx is pre-shifted and zero-filled, so fall 24 leaves mosi at 0
        if (fall_tick && (state_q == ST_SHIFT)) begin
            mosi_d = tx_q[FRAME_BITS-1];
            tx_d   = {tx_q[FRAME_BITS-2:0], 1'b0};
        end

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (cmd_valid && cmd_ready) begin
                    state_d = ST_CS_SETUP;
                    busy_d  = 1'b1;
                    csn_d   = 1'b0;
                    cyc_d   = '0;
                    edge_d  = 6'd0;
                    rw_d    = cmd_rw;
                    rx_d    = 8'h00;
                    mosi_d  = frame_w[FRAME_BITS-1];
                    tx_d    = {frame_w[FRAME_BITS-2:0], 1'b0};
                end
            end
            ST_CS_SETUP: begin
                if (cyc_q == CSS_LAST) begin
                    state_d = ST_SHIFT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_SHIFT: begin
                if (half_end && (edge_q == EDGE_LAST)) begin
                    state_d = ST_CS_HOLD;
                    cyc_d   = '0;
                end
            end
            ST_CS_HOLD: begin
                if (cyc_q == CSH_LAST) begin
`ifdef SPI_FLUSH_CLK_EN
                    state_d = ST_FLUSH;
                    csn_d   = 1'b1;
                    edge_d  = 6'd0;
`else
                    state_d     = ST_IDLE;
                    csn_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rw_q ? rx_q : 8'h00;
`endif
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            ST_FLUSH: begin
`ifdef SPI_FLUSH_CLK_EN
                // edge 2 is the flush fall; finish at the end of its low half
                if ((edge_q == 6'd2) && half_end) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = rw_q ? rx_q : 8'h00;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cyc_q       <= '0;
            edge_q      <= 6'd0;
            tx_q        <= '0;
            rx_q        <= 8'h00;
            rw_q        <= 1'b0;
            csn_q       <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            edge_q      <= edge_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            rw_q        <= rw_d;
            csn_q       <= csn_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign csn_o     = csn_q;
    assign mosi_o    = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mcp_spi_master.sv
// ---------------------------------------------------------------------------
// tb_mcp_spi_master
// Scoreboard bench for mcp_spi_master with an MCP23S17-style sink model.
// The reference model is a register array updated by issued commands; the
// expected frame, read data and latency are pushed at accept and checked by
// a monitor on rsp_valid. Honors SPI_FLUSH_CLK_EN for rise count/latency.
// ---------------------------------------------------------------------------
module tb_mcp_spi_master;

    localparam int         CLK_DIV = 4;
    localparam logic [2:0] DEV     = 3'b101;
    localparam int         CSS     = 2;
    localparam int         CSH     = 2;
`ifdef SPI_FLUSH_CLK_EN
    localparam int FLUSH_CYC = 2 * CLK_DIV + 1;
    localparam int RISES     = 25;
`else
    localparam int FLUSH_CYC = 0;
    localparam int RISES     = 24;
`endif
    localparam int LAT = 1 + CSS + 48 * CLK_DIV + CSH + FLUSH_CYC;

    logic       clk = 1'b0;
    logic       rstn;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [7:0] cmd_addr, cmd_wdata;
    logic       rsp_valid, busy, sclk_o, csn_o, mosi_o, miso_i;
    logic [7:0] rsp_rdata;

    typedef struct {
        logic [7:0]  rdata;
        logic [23:0] frame;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0, failures = 0;
    int          cyc = 0, n_exp = 0, n_rsp = 0;
    logic [7:0]  ref_mem [256];
    logic [7:0]  held_exp = 8'h00;

    // sink state
    logic [7:0]  sink_mem [256];
    logic [23:0] sh, last_frame;
    int          bit_cnt, rise_cnt, last_bits;
    logic        rd_en;
    logic [7:0]  rd_addr;

    mcp_spi_master #(
        .CLK_DIV (CLK_DIV),
        .DEV_ADDR(DEV),
        .CSS_CYC (CSS),
        .CSH_CYC (CSH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .sclk_o    (sclk_o),
        .csn_o     (csn_o),
        .mosi_o    (mosi_o),
        .miso_i    (miso_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Power-on register contents assumed for the sink device
    function automatic logic [7:0] init_val(input logic [7:0] a);
        return (a * 8'd13) ^ 8'hC3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Sink: mode 0, samples on rise, launches read data on falls after rise 16
    initial begin
        logic p_csn, p_sclk;
        for (int i = 0; i < 256; i++) sink_mem[i] = init_val(8'(i));
        p_csn = 1'b1; p_sclk = 1'b0; miso_i = 1'b0;
        sh = '0; last_frame = '0; bit_cnt = 0; rise_cnt = 0; last_bits = 0;
        rd_en = 1'b0; rd_addr = 8'h00;
        forever begin
            @(sclk_o or csn_o);
            if (csn_o === 1'b1 && p_csn === 1'b0) begin
                last_frame = sh;
                last_bits  = bit_cnt;
            end
            if (csn_o === 1'b0 && p_csn === 1'b1) begin
                sh = '0; bit_cnt = 0; rise_cnt = 0; rd_en = 1'b0;
            end
            if (sclk_o === 1'b1 && p_sclk === 1'b0) begin
                rise_cnt++;
                if (csn_o === 1'b0) begin
                    sh = {sh[22:0], mosi_o};
                    bit_cnt++;
                    if (bit_cnt == 16) begin
                        rd_en   = (sh[15:12] == 4'b0100) && (sh[11:9] == DEV) && sh[8];
                        rd_addr = sh[7:0];
                    end
                    if (bit_cnt == 24 && sh[23:20] == 4'b0100 && sh[19:17] == DEV && !sh[16])
                        sink_mem[sh[15:8]] = sh[7:0];
                end
            end
            if (sclk_o === 1'b0 && p_sclk === 1'b1 && csn_o === 1'b0) begin
                if (rd_en && bit_cnt >= 16 && bit_cnt < 24) miso_i = sink_mem[rd_addr][23 - bit_cnt];
                else miso_i = 1'($urandom);
            end
            p_csn  = csn_o;
            p_sclk = sclk_o;
        end
    end

    // Monitor: pops the scoreboard on every response
    always @(negedge clk) begin
        exp_t e;
        if (!rstn) begin
            held_exp = 8'h00;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_without_cmd: got rsp_valid with rdata 0x%0h, expected no response", rsp_rdata);
            end else begin
                e = sb.pop_front();
                n_rsp++;
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("latency", cyc - e.acc, LAT);
                chk("mosi_frame", last_frame, e.frame);
                chk("frame_bits", last_bits, 24);
                chk("sclk_rises", rise_cnt, RISES);
                chk("csn_at_rsp", csn_o, 1'b1);
                chk("sclk_at_rsp", sclk_o, 1'b0);
                chk("mosi_at_rsp", mosi_o, 1'b0);
                chk("busy_at_rsp", busy, 1'b1);
                chk("ready_at_rsp", cmd_ready, 1'b0);
                held_exp = e.rdata;
            end
        end else begin
            chk("rdata_hold", rsp_rdata, held_exp);
        end
    end

    // Drive one command (called at a negedge); returns at the negedge after accept
    task automatic issue(input logic rw, input logic [7:0] a, input logic [7:0] d, input bit keep);
        exp_t e;
        bit   ok;
        cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(posedge clk);
            if (cmd_ready) ok = 1'b1;
        end
        if (ok) begin
            e.rdata = rw ? ref_mem[a] : 8'h00;
            e.frame = {4'b0100, DEV, rw, a, d};
            e.acc   = cyc;
            if (!rw) ref_mem[a] = d;
            sb.push_back(e);
            n_exp++;
        end else begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: cmd_ready stayed 0 for 2000 cycles, expected 1");
        end
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        chk("csn_after_accept", csn_o, 1'b0);
        chk("busy_after_accept", busy, 1'b1);
    endtask

    initial begin
        logic [7:0] addrs [5];
        bit         hit;
        addrs[0] = 8'h0A; addrs[1] = 8'h12; addrs[2] = 8'h00; addrs[3] = 8'h5A; addrs[4] = 8'h33;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        rstn = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_csn", csn_o, 1'b1);
        chk("rst_sclk", sclk_o, 1'b0);
        chk("rst_mosi", mosi_o, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rdata", rsp_rdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Directed: write, reads of 0xF0 / 0x0F, DEV_ADDR opcode bytes
        issue(1'b0, 8'h0A, 8'h5A, 1'b0);
        issue(1'b0, 8'h12, 8'hF0, 1'b0);
        issue(1'b1, 8'h12, 8'h00, 1'b0);
        issue(1'b0, 8'h12, 8'h0F, 1'b0);
        issue(1'b1, 8'h12, 8'h77, 1'b0);
        issue(1'b0, 8'h00, 8'hFF, 1'b0);
        issue(1'b1, 8'h00, 8'h00, 1'b0);
        issue(1'b1, 8'h0A, 8'h00, 1'b0);

        // Back-to-back with cmd_valid held high
        issue(1'b1, 8'h5A, 8'h11, 1'b1);
        issue(1'b0, 8'h5A, 8'hC6, 1'b1);
        issue(1'b1, 8'h5A, 8'h22, 1'b0);

        // Command pulse while busy is dropped
        issue(1'b1, 8'h33, 8'h00, 1'b0);
        repeat (40) @(negedge clk);
        cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h33; cmd_wdata = 8'($urandom);
        @(posedge clk);
        chk("ready_while_busy", cmd_ready, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;

        // Reset at SCLK rise 10 of a read
        issue(1'b1, 8'h5A, 8'h00, 1'b0);
        hit = 1'b0;
        for (int n = 0; n < 1000 && !hit; n++) begin
            @(negedge clk);
            if (rise_cnt == 10) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL rise10_timeout: rise count %0d, expected to reach 10", rise_cnt);
        end
        rstn = 1'b0;
        #1;
        chk("midrst_csn", csn_o, 1'b1);
        chk("midrst_sclk", sclk_o, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        sb.delete();
        n_exp--;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        issue(1'b1, 8'h5A, 8'h00, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            issue(1'($urandom), addrs[$urandom_range(0, 4)], 8'($urandom), bit'($urandom_range(0, 1)));
        end
        cmd_valid = 1'b0;

        for (int n = 0; n < 3000 && sb.size() != 0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("rsp_count", n_rsp, n_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
